axi4_lite_slave_read_pipe: RTL and testbench

- Parametrised AXI4-Lite read slave that bridges an external AXI4-Lite master to the internal memory read port.
- Buffers up to AR_DEPTH accepted read addresses in a FIFO and issues them in order on a req/ack memory interface.
- Returns data in order on the R channel, with OKAY, SLVERR or DECERR responses.
- Adds address-range/alignment decode and a per-access timeout.

---
 rtl/axi4_lite_slave_read_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave_read_pipe.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_read_pipe.sv
// AXI4-Lite read slave: AR FIFO, range/alignment decode,
// in-order single-outstanding memory issue with per-access timeout.
module axi4_lite_slave_read_pipe #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AR_DEPTH       = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = '1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      AR_VALID,
  input  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  input  logic [2:0]                AR_PROT,
  output logic                      AR_READY,
  input  logic                      R_READY,
  output logic [AXI_DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]                R_RESP,
  output logic                      R_VALID,
  output logic                      mem_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [2:0]                mem_prot_o,
  input  logic                      mem_ack_i,
  input  logic                      mem_err_i,
  input  logic [AXI_DATA_WIDTH-1:0] mem_data_i,
  output logic                      busy_o
);

  localparam int unsigned OFFW = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned PW   = $clog2(AR_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned TW   =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(AR_DEPTH);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam bit            TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [2:0]                prot;
    logic                      dec_err;
  } ar_ent_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  // Address decode; bounds at the ends of the space need no compare.
  logic lo_ok;
  logic hi_ok;
  logic al_ok;
  logic dec_err;

  if (ADDR_BASE == '0) begin : g_lo_any
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (AR_ADDR >= ADDR_BASE);
  end

  if (ADDR_LIMIT == '1) begin : g_hi_any
    assign hi_ok = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok = (AR_ADDR <= ADDR_LIMIT);
  end

  assign al_ok   = (AR_ADDR[OFFW-1:0] == '0);
  assign dec_err = ~(lo_ok & hi_ok & al_ok);

  // AR FIFO
  ar_ent_t       fifo_q [AR_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  ar_ent_t       head;

  state_t state;
  state_t state_nxt;

  assign AR_READY = ~arst_i & (count != FULL);
  assign push     = AR_VALID & AR_READY;
  assign pop      = (state == IDLE) & (count != '0);
  assign head     = fifo_q[rptr];
  assign busy_o   = (state != IDLE) | (count != '0);

  // FIFO storage, written on an accepted AR beat
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr] <= '{addr: AR_ADDR,
                        prot: AR_PROT,
                        dec_err: dec_err};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Access FSM registers
  logic                      req_q;
  logic                      req_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_nxt;
  logic [2:0]                prot_q;
  logic [2:0]                prot_nxt;
  logic                      rv_q;
  logic                      rv_nxt;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_nxt;
  logic [1:0]                rresp_q;
  logic [1:0]                rresp_nxt;
  logic [TW-1:0]             timer_q;
  logic [TW-1:0]             timer_nxt;
  logic [TW-1:0]             timer_inc;

  assign timer_inc = timer_q + TW'(1);

  // Next state: issue head, wait for ack or timeout, hold R beat
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    prot_nxt  = prot_q;
    rv_nxt    = rv_q;
    rdata_nxt = rdata_q;
    rresp_nxt = rresp_q;
    timer_nxt = timer_q;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          if (head.dec_err) begin
            rv_nxt    = 1'b1;
            rdata_nxt = '0;
            rresp_nxt = RESP_DECERR;
            state_nxt = RESP;
          end else begin
            req_nxt   = 1'b1;
            addr_nxt  = head.addr;
            prot_nxt  = head.prot;
            timer_nxt = '0;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          req_nxt   = 1'b0;
          rv_nxt    = 1'b1;
          rdata_nxt = mem_err_i ? '0 : mem_data_i;
          rresp_nxt = mem_err_i ? RESP_SLVERR : RESP_OKAY;
          state_nxt = RESP;
        end else if (TO_EN && timer_inc == TLIM) begin
          req_nxt   = 1'b0;
          rv_nxt    = 1'b1;
          rdata_nxt = '0;
          rresp_nxt = RESP_SLVERR;
          state_nxt = RESP;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      RESP: begin
        if (R_READY) begin
          rv_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      prot_q  <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      timer_q <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      prot_q  <= prot_nxt;
      rv_q    <= rv_nxt;
      rdata_q <= rdata_nxt;
      rresp_q <= rresp_nxt;
      timer_q <= timer_nxt;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign mem_prot_o = prot_q;
  assign R_VALID    = rv_q;
  assign R_DATA     = rdata_q;
  assign R_RESP     = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_read_pipe.sv
// Bench for axi4_lite_slave_read_pipe: directed scenarios plus
// random traffic checked against an in-order response model.
module tb_axi4_lite_slave_read_pipe;

  logic        clk_i;
  logic        arst_i;
  logic        AR_VALID;
  logic [31:0] AR_ADDR;
  logic [2:0]  AR_PROT;
  logic        AR_READY;
  logic        R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_VALID;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [2:0]  mem_prot_o;
  logic        mem_ack_i;
  logic        mem_err_i;
  logic [31:0] mem_data_i;
  logic        busy_o;

  axi4_lite_slave_read_pipe #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AR_DEPTH(4),
    .ADDR_BASE(32'h0000_1000),
    .ADDR_LIMIT(32'h0000_1FFF),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i),
    .arst_i(arst_i),
    .AR_VALID(AR_VALID),
    .AR_ADDR(AR_ADDR),
    .AR_PROT(AR_PROT),
    .AR_READY(AR_READY),
    .R_READY(R_READY),
    .R_DATA(R_DATA),
    .R_RESP(R_RESP),
    .R_VALID(R_VALID),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_prot_o(mem_prot_o),
    .mem_ack_i(mem_ack_i),
    .mem_err_i(mem_err_i),
    .mem_data_i(mem_data_i),
    .busy_o(busy_o)
  );

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam int TO = 8;

  int n_chk = 0;
  int n_err = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit dec_bad(input logic [31:0] a);
    return (a < 32'h1000) || (a > 32'h1FFF) || (a[1:0] != 2'b00);
  endfunction

  // One read with a scripted memory: ack in req cycle dly (<0: never)
  task automatic rd(input  logic [31:0] a,
                    input  int          dly,
                    input  logic        err,
                    input  logic [31:0] d,
                    input  int          hold,
                    output logic [31:0] rdata,
                    output logic [1:0]  rresp,
                    output int          req_cyc,
                    output int          lat);
    int n;
    R_READY = 1'b0;
    @(negedge clk_i);
    AR_VALID = 1'b1;
    AR_ADDR  = a;
    AR_PROT  = 3'b011;
    n = 0;
    while (!AR_READY && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!AR_READY) chk("rd_ar_wait", 0, 1);
    @(negedge clk_i);
    AR_VALID = 1'b0;
    lat = 0;
    req_cyc = 0;
    while (!R_VALID && lat < 60) begin
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        chk("rd_maddr", mem_addr_o, a);
        chk("rd_mprot", mem_prot_o, 3'b011);
        if (req_cyc == dly) begin
          mem_ack_i  = 1'b1;
          mem_err_i  = err;
          mem_data_i = d;
        end
        req_cyc++;
      end
      @(negedge clk_i);
      lat++;
    end
    mem_ack_i = 1'b0;
    if (!R_VALID) chk("rd_rvalid_wait", 0, 1);
    rdata = R_DATA;
    rresp = R_RESP;
    for (int i = 0; i < hold; i++) begin
      if (dly < 0 && i == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hBAD0_BAD0;
        mem_err_i  = 1'b0;
      end else begin
        mem_ack_i = 1'b0;
      end
      @(negedge clk_i);
      chk("hold_v", R_VALID, 1);
      chk("hold_d", R_DATA, rdata);
      chk("hold_r", R_RESP, rresp);
    end
    mem_ack_i = 1'b0;
    R_READY = 1'b1;
    @(negedge clk_i);
    R_READY = 1'b0;
    chk("rv_drop", R_VALID, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  // Random-phase model state
  logic [34:0] acc_q [$];
  logic [33:0] exp_q [$];
  bit          active;
  int          mcyc;
  int          mdly;
  bit          prev_rv;
  bit          prev_rhs;
  logic [31:0] prev_rd;
  logic [1:0]  prev_rr;
  bit          ar_hs_last;
  int          n_beats;
  int          n_acc;

  task automatic rnd_step(input bit gen);
    logic [31:0] a;
    logic [33:0] e;
    logic [34:0] h;
    logic        er;
    int          r;
    if (prev_rv && !prev_rhs) begin
      chk("rh_v", R_VALID, 1);
      chk("rh_d", R_DATA, prev_rd);
      chk("rh_r", R_RESP, prev_rr);
    end
    while (acc_q.size() != 0) begin
      h = acc_q[0];
      a = h[31:0];
      if (!dec_bad(a)) break;
      exp_q.push_back({2'b11, 32'h0});
      void'(acc_q.pop_front());
    end
    mem_ack_i = 1'b0;
    if (!active && mem_req_o) begin
      active = 1'b1;
      mcyc = 0;
      r = int'($urandom_range(0, 19));
      mdly = (r < 14) ? r % 4 : (r < 17) ? 4 + r % 4 : 8 + r % 2;
      if (acc_q.size() == 0) chk("m_spurious", 1, 0);
    end
    if (active) begin
      if (acc_q.size() != 0) h = acc_q[0];
      else h = '0;
      if (mcyc < TO) begin
        chk("m_req", mem_req_o, 1);
        chk("m_addr", mem_addr_o, h[31:0]);
        chk("m_prot", mem_prot_o, h[34:32]);
      end
      if (mdly < TO && mcyc == mdly) begin
        er = ($urandom_range(0, 3) == 0);
        mem_ack_i  = 1'b1;
        mem_err_i  = er;
        mem_data_i = $urandom;
        e = er ? {2'b10, 32'h0} : {2'b00, mem_data_i};
        exp_q.push_back(e);
        if (acc_q.size() != 0) void'(acc_q.pop_front());
        active = 1'b0;
      end else if (mdly >= TO && mcyc == TO) begin
        chk("m_timeout_drop", mem_req_o, 0);
        mem_ack_i  = 1'b1;
        mem_err_i  = 1'b0;
        mem_data_i = $urandom;
        exp_q.push_back({2'b10, 32'h0});
        if (acc_q.size() != 0) void'(acc_q.pop_front());
        active = 1'b0;
      end
      mcyc++;
    end
    R_READY = gen ? ($urandom_range(0, 9) < 6) : 1'b1;
    prev_rhs = R_VALID && R_READY;
    if (prev_rhs) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        chk("r_extra", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("r_data", R_DATA, e[31:0]);
        chk("r_resp", R_RESP, e[33:32]);
      end
    end
    prev_rv = R_VALID;
    prev_rd = R_DATA;
    prev_rr = R_RESP;
    if (!(AR_VALID && !ar_hs_last)) begin
      AR_VALID = gen && ($urandom_range(0, 9) < 5);
      r = int'($urandom_range(0, 9));
      if (r < 6)
        a = 32'h1000 + ($urandom_range(0, 1023) << 2);
      else if (r == 6)
        a = 32'h1000 + ($urandom_range(0, 1023) << 2)
            + $urandom_range(1, 3);
      else if (r == 7)
        a = $urandom_range(0, 32'hFFF);
      else if (r == 8)
        a = 32'h2000 + $urandom_range(0, 32'h7FFF_0000);
      else
        a = 32'hFFFF_FFFC;
      AR_ADDR = a;
      AR_PROT = 3'($urandom_range(0, 7));
    end
    ar_hs_last = AR_VALID && AR_READY;
    if (ar_hs_last) begin
      acc_q.push_back({AR_PROT, AR_ADDR});
      n_acc++;
    end
  endtask

  initial begin
    logic [31:0] rdat;
    logic [1:0]  rrsp;
    int          rq;
    int          lt;
    int          acc;
    int          k;
    int          n;
    bit          hs;
    arst_i     = 1'b1;
    AR_VALID   = 1'b0;
    AR_ADDR    = '0;
    AR_PROT    = '0;
    R_READY    = 1'b0;
    mem_ack_i  = 1'b0;
    mem_err_i  = 1'b0;
    mem_data_i = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_arready", AR_READY, 0);
    chk("rst_rvalid", R_VALID, 0);
    chk("rst_mreq", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rdata", R_DATA, 0);
    arst_i = 1'b0;
    #1;
    chk("rel_arready", AR_READY, 1);

    // Single read, ack in first REQ cycle
    rd(32'h1100, 0, 1'b0, 32'hDEAD_BEEF, 0, rdat, rrsp, rq, lt);
    chk("sr_lat", lt, 2);
    chk("sr_reqcyc", rq, 1);
    chk("sr_data", rdat, 32'hDEAD_BEEF);
    chk("sr_resp", rrsp, 2'b00);

    // FIFO fill with R stalled and memory acking at once
    @(negedge clk_i);
    R_READY   = 1'b0;
    mem_ack_i = 1'b1;
    mem_err_i = 1'b0;
    AR_VALID  = 1'b1;
    AR_ADDR   = 32'h1000;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      mem_data_i = mem_addr_o ^ K;
      hs = AR_VALID && AR_READY;
      @(negedge clk_i);
      if (hs) begin
        acc++;
        AR_ADDR = AR_ADDR + 32'd4;
      end
    end
    chk("fill_accepts", acc, 5);
    chk("fill_arready", AR_READY, 0);
    chk("fill_busy", busy_o, 1);
    AR_VALID = 1'b0;
    R_READY  = 1'b1;
    k = 0;
    n = 0;
    while (k < 5 && n < 60) begin
      mem_data_i = mem_addr_o ^ K;
      if (R_VALID && R_READY) begin
        chk("fill_data", R_DATA, (32'h1000 + 32'(4 * k)) ^ K);
        chk("fill_resp", R_RESP, 2'b00);
        k++;
      end
      @(negedge clk_i);
      n++;
    end
    chk("fill_beats", k, 5);
    mem_ack_i = 1'b0;
    R_READY   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("fill_no_extra", R_VALID, 0);
    chk("fill_idle", busy_o, 0);

    // Decode errors, then the top aligned word in range
    rd(32'h0FFC, 0, 1'b0, 32'h1111_1111, 1, rdat, rrsp, rq, lt);
    chk("dec_lo_resp", rrsp, 2'b11);
    chk("dec_lo_data", rdat, 0);
    chk("dec_lo_req", rq, 0);
    rd(32'h2000, 0, 1'b0, 32'h2222_2222, 0, rdat, rrsp, rq, lt);
    chk("dec_hi_resp", rrsp, 2'b11);
    chk("dec_hi_data", rdat, 0);
    chk("dec_hi_req", rq, 0);
    rd(32'h1002, 0, 1'b0, 32'h3333_3333, 0, rdat, rrsp, rq, lt);
    chk("dec_al_resp", rrsp, 2'b11);
    chk("dec_al_data", rdat, 0);
    chk("dec_al_req", rq, 0);
    rd(32'h1FFC, 0, 1'b0, 32'h4444_4444, 0, rdat, rrsp, rq, lt);
    chk("dec_top_resp", rrsp, 2'b00);
    chk("dec_top_data", rdat, 32'h4444_4444);

    // Timeout, late ack, then a normal read
    rd(32'h1300, -1, 1'b0, 32'h0, 2, rdat, rrsp, rq, lt);
    chk("to_reqcyc", rq, TO);
    chk("to_resp", rrsp, 2'b10);
    chk("to_data", rdat, 0);
    rd(32'h1304, 0, 1'b0, 32'hCAFE_F00D, 0, rdat, rrsp, rq, lt);
    chk("post_to_resp", rrsp, 2'b00);
    chk("post_to_data", rdat, 32'hCAFE_F00D);

    // Memory error under R backpressure
    rd(32'h1200, 0, 1'b1, 32'h1234_5678, 5, rdat, rrsp, rq, lt);
    chk("merr_resp", rrsp, 2'b10);
    chk("merr_data", rdat, 0);

    // Reset while a request is outstanding and two are queued
    @(negedge clk_i);
    AR_VALID = 1'b1;
    AR_ADDR  = 32'h1400;
    @(negedge clk_i);
    AR_ADDR  = 32'h1404;
    @(negedge clk_i);
    AR_ADDR  = 32'h1408;
    @(negedge clk_i);
    AR_VALID = 1'b0;
    chk("mr_req_before", mem_req_o, 1);
    chk("mr_busy_before", busy_o, 1);
    #2;
    arst_i = 1'b1;
    #1;
    chk("mr_req_async", mem_req_o, 0);
    chk("mr_busy_async", busy_o, 0);
    chk("mr_rvalid_async", R_VALID, 0);
    @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    chk("mr_arready", AR_READY, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("mr_no_beat", R_VALID, 0);
      chk("mr_no_req", mem_req_o, 0);
    end
    rd(32'h1500, 1, 1'b0, 32'h55AA_33CC, 1, rdat, rrsp, rq, lt);
    chk("mr_new_resp", rrsp, 2'b00);
    chk("mr_new_data", rdat, 32'h55AA_33CC);

    // Random traffic against the in-order model
    active     = 1'b0;
    prev_rv    = 1'b0;
    prev_rhs   = 1'b0;
    ar_hs_last = 1'b0;
    n_beats    = 0;
    n_acc      = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      rnd_step(c < 1800);
    end
    n = 0;
    while ((acc_q.size() != 0 || exp_q.size() != 0 || busy_o)
           && n < 300) begin
      @(negedge clk_i);
      rnd_step(1'b0);
      n++;
    end
    chk("rnd_drained", acc_q.size() + exp_q.size(), 0);
    chk("rnd_beats", n_beats, n_acc);
    @(negedge clk_i);
    chk("rnd_idle", busy_o, 0);
    R_READY = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
